fifo_rst_req: RTL
=================

FIFO_RST_REQ -- requirements
Module: fifo_rst_req

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RST  input  1  asynchronous, active-high reset.
REQ-003 RESTART_REQ  input  1  restart request from auto-load logic; single-cycle pulse or level, sampled per cycle.
REQ-004 DONE  input  1  ready flag from the FIFO reset sequencer; high = FIFOs reset and running.
REQ-005 AL_RESTART  output  1  restart command to the FIFO reset sequencer; exactly one-cycle pulse per attempt.
REQ-006 WR_ALLOW  output  1  write-enable gate for FIFO writers; high only when sequencer is confirmed ready.
REQ-007 BUSY  output  1  high while a restart is in progress (Request, Wait_Drop, Wait_Done).
REQ-008 TIMEOUT_ERR  output  1  sticky error; sequencer failed to respond after all retries.
REQ-009 RETRY_CNT  output  2  attempts used in the current or last restart, 0..3.

Function
REQ-010 The FSM SHALL have six states: Init, Ready, Request, Wait_Drop, Wait_Done, Error. All outputs are registered and decoded from next state.
REQ-011 Init: WR_ALLOW=0. Go to Ready when DONE=1. No timeout applies.
REQ-012 Ready: WR_ALLOW=1. Go to Request when RESTART_REQ=1. Go to Init when DONE falls without a request; this is an unsolicited sequencer reset.
REQ-013 Request: lasts exactly one cycle with AL_RESTART=1, then goes to Wait_Drop. Clear the timer. Increment RETRY_CNT, saturating at 3.
REQ-014 Wait_Drop: go to Wait_Done when DONE=0. If the timer reaches 7 with DONE still 1, retry.
REQ-015 Wait_Done: go to Ready when DONE=1, keeping RETRY_CNT. If the timer reaches 63, retry.
REQ-016 Retry: go to Request if RETRY_CNT<3; otherwise go to Error.
REQ-017 Error: set TIMEOUT_ERR=1 and WR_ALLOW=0. Leave only on a RESTART_REQ, which clears TIMEOUT_ERR, zeroes RETRY_CNT and enters Request.
REQ-018 On entry to Request from Ready or Error, RETRY_CNT SHALL first load 0 and then increment, so the first attempt reads 1.
REQ-019 The timer SHALL be a 6-bit counter, cleared on every state change and incremented each cycle in the Wait states. It saturates and never wraps.
REQ-020 RESTART_REQ SHALL be ignored in Init, Request, Wait_Drop and Wait_Done; requests are not queued.
REQ-021 WR_ALLOW SHALL fall in the same cycle AL_RESTART rises. It SHALL rise no earlier than one cycle after DONE is sampled high.
REQ-022 If RESTART_REQ and a falling DONE occur in the same cycle in Ready, the FSM SHALL take Request.

Reset
REQ-023 On RST the FSM SHALL go to Init and set AL_RESTART=0, WR_ALLOW=0, BUSY=0, TIMEOUT_ERR=0, RETRY_CNT=0 and timer=0.
REQ-024 RST asserted mid-restart SHALL abort immediately; no AL_RESTART pulse is issued after RST deasserts until a new RESTART_REQ arrives.

Structure
REQ-025 State encodings (3-bit), the timeout limits (7, 63) and MAX_RETRY=3 SHALL live in the shared FIFO-control package used by the FIFO reset sequencer.
REQ-026 The block SHALL be a single module with no sub-modules. The timer is inline.
REQ-027 A simulation-only state-name decode SHALL be provided.

Verification
REQ-028 Scenario 1: release RST with DONE=0, raise DONE at cycle 10 -> WR_ALLOW=1 at cycle 11; BUSY=0 throughout.
REQ-029 Scenario 2: in Ready, pulse RESTART_REQ; the sequencer model drops DONE 1 cycle later and raises it 33 cycles later -> AL_RESTART pulses once, WR_ALLOW returns, RETRY_CNT=1.
REQ-030 Scenario 3: in Ready, pulse RESTART_REQ with DONE held 1 -> three AL_RESTART pulses 9 cycles apart, then TIMEOUT_ERR=1, RETRY_CNT=3, WR_ALLOW=0.
REQ-031 Scenario 4: DONE drops and never returns -> retries on a 64-cycle timeout and ends in Error. A new RESTART_REQ then clears TIMEOUT_ERR and issues AL_RESTART.
REQ-032 Scenario 5: assert RST in Wait_Done -> all outputs are at reset values in the same cycle, and no AL_RESTART appears afterwards without a request.
REQ-033 Scenario 6: drop DONE in Ready without a request -> WR_ALLOW=0 next cycle, state is Init, no AL_RESTART.

Source files
------------

// File: rtl/fifo_rst_req_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rst_req_pkg
//  Brief    : Shared FIFO-control definitions: restart FSM state encodings,
//             timeout limits and retry budget.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_rst_req_pkg;

  // 3-bit state encoding shared with the FIFO reset sequencer
  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_READY     = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_WAIT_DROP = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_ERROR     = 3'd5
  } state_t;

  localparam int              TIMER_W      = 6;
  // Timer value at which the sequencer is considered unresponsive
  localparam logic [TIMER_W-1:0] DROP_TIMEOUT = 6'd7;
  localparam logic [TIMER_W-1:0] DONE_TIMEOUT = 6'd63;
  localparam logic [1:0]         MAX_RETRY    = 2'd3;

`ifndef SYNTHESIS
  // Human-readable state name for waveform viewers and debug prints
  function automatic string state_name(state_t s);
    case (s)
      ST_INIT:      return "INIT";
      ST_READY:     return "READY";
      ST_REQUEST:   return "REQUEST";
      ST_WAIT_DROP: return "WAIT_DROP";
      ST_WAIT_DONE: return "WAIT_DONE";
      ST_ERROR:     return "ERROR";
      default:      return "ILLEGAL";
    endcase
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/fifo_rst_req.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rst_req
//  Brief    : Issues restart commands to the FIFO reset sequencer, waits for
//             DONE to drop and return, retries on timeout and gates FIFO
//             writes until the sequencer reports ready.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_rst_req
  import fifo_rst_req_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       restart_req,
  input  logic       done,
  output logic       al_restart,
  output logic       wr_allow,
  output logic       busy,
  output logic       timeout_err,
  output logic [1:0] retry_cnt
);

  localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

  state_t              state;
  state_t              next_state;
  logic                do_retry;
  logic [TIMER_W-1:0]  timer;

  // Next-state decision; a retry is resolved after the per-state logic
  always_comb begin
    next_state = state;
    do_retry   = 1'b0;
    case (state)
      ST_INIT: begin
        if (done) next_state = ST_READY;
      end
      ST_READY: begin
        // A request wins over a simultaneous DONE drop
        if (restart_req)  next_state = ST_REQUEST;
        else if (!done)   next_state = ST_INIT;
      end
      ST_REQUEST: begin
        next_state = ST_WAIT_DROP;
      end
      ST_WAIT_DROP: begin
        if (!done)                      next_state = ST_WAIT_DONE;
        else if (timer == DROP_TIMEOUT) do_retry   = 1'b1;
      end
      ST_WAIT_DONE: begin
        if (done)                       next_state = ST_READY;
        else if (timer == DONE_TIMEOUT) do_retry   = 1'b1;
      end
      ST_ERROR: begin
        if (restart_req) next_state = ST_REQUEST;
      end
      default: begin
        next_state = ST_INIT;
      end
    endcase
    if (do_retry) begin
      next_state = (retry_cnt < MAX_RETRY) ? ST_REQUEST : ST_ERROR;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INIT;
    else     state <= next_state;
  end

  // Wait timer: cleared on any state change, counts in the wait states, saturates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (next_state != state) begin
      timer <= '0;
    end else if ((state == ST_WAIT_DROP || state == ST_WAIT_DONE) && timer != TIMER_MAX) begin
      timer <= timer + 6'd1;
    end
  end

  // Attempt counter: a fresh restart (from Ready/Error) reads 1, a retry adds one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retry_cnt <= 2'd0;
    end else if (next_state == ST_REQUEST) begin
      if (state == ST_READY || state == ST_ERROR) retry_cnt <= 2'd1;
      else if (retry_cnt != MAX_RETRY)            retry_cnt <= retry_cnt + 2'd1;
    end
  end

  // Registered outputs decoded from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      al_restart  <= 1'b0;
      wr_allow    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      al_restart  <= (next_state == ST_REQUEST);
      wr_allow    <= (next_state == ST_READY);
      busy        <= (next_state == ST_REQUEST) || (next_state == ST_WAIT_DROP) ||
                     (next_state == ST_WAIT_DONE);
      timeout_err <= (next_state == ST_ERROR);
    end
  end

endmodule
`default_nettype wire
